ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave front end for the on-chip SRAM macro; sits directly upstream of the SRAM and drives its word address, write data, write enable and 4-bit byte enables. Converts pipelined AHB address/data phases into single-cycle SRAM accesses with zero wait states for legal transfers. Returns a two-cycle ERROR response for out-of-range, misaligned or unsupported-size transfers.

## Interface
- ADDRBIT, 16, SRAM word-address width
- DATABIT, 32, data width (fixed 32; byte_en is 4 bits)
- BASEADDR, 32'h0000_0000, byte base address of the SRAM window
- SIZE_WORDS, 65536, words in the window (≤ 2**ADDRBIT)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address (address phase)
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 halfword, 2 word; others illegal
- HREADY  in  1  bus-wide ready (transfer-accept qualifier)
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data (data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR
- ram_addr  out  ADDRBIT  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_wen  out  1  SRAM write enable
- ram_byte_en  out  4  SRAM byte lane enables
- ram_rdata  in  32  SRAM combinational read data

## Operation
- Accept = HSEL & HTRANS[1] & HREADY. BUSY/IDLE or HSEL=0 → no access, OKAY.
- On accept, register: word address (HADDR−BASEADDR)>>2, HWRITE, byte enables, error flag.
- Byte enables: HSIZE 0 → 4'b0001<<HADDR[1:0]; HSIZE 1 → HADDR[1] ? 4'b1100 : 4'b0011; HSIZE 2 → 4'b1111.
- Error if any: HSIZE>2; HSIZE 1 with HADDR[0]=1; HSIZE 2 with HADDR[1:0]≠0; HADDR<BASEADDR; HADDR−BASEADDR ≥ SIZE_WORDS*4 (compute in 33 bits, no wrap).
- FSM states: IDLE (no data phase), WR_DP, RD_DP, ERR1, ERR2.
  - IDLE/WR_DP/RD_DP/ERR2: on accept → WR_DP/RD_DP (legal) or ERR1 (illegal); else → IDLE.
  - ERR1 → ERR2 unconditionally (HREADY low, no accept).
- WR_DP: ram_wen=1, ram_wdata=HWDATA, ram_byte_en=registered enables, ram_addr=registered address.
- RD_DP: ram_wen=0, HRDATA=ram_rdata (full word; master selects lanes).
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. No SRAM write in either.
- ram_addr always = registered word address; ram_byte_en = 0 outside WR_DP.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=ram_rdata (ram_addr=0), ram_wen=0, ram_byte_en=0, ram_addr=0, state IDLE.
- Legal transfers: zero wait states; read data valid combinationally in data phase; write commits at the edge ending the data phase.
- Back-to-back write A then read A: read returns the new data (write committed one edge before read data phase).
- Error: exactly 2 data-phase cycles; a new transfer presented in ERR2 is accepted normally.
- rst mid-data-phase: pending write dropped (no ram_wen after reset), FSM → IDLE, error sequence aborted.
- HTRANS=BUSY inside a burst: OKAY, no SRAM access, state → IDLE.

## Structure
- Package ahb_pkg: htrans_t (IDLE, BUSY, NONSEQ, SEQ), hsize_t (BYTE, HALF, WORD), sram_slave_state_t, HRESP_OKAY/HRESP_ERROR constants.
- Sub-module ahb_byte_lane_decode: combinational HSIZE+HADDR[1:0] → byte_en[3:0] and misaligned/illegal flag.
- Top: address/range check, phase registers, FSM, output muxing.

## Test plan
- Word write 32'hDEADBEEF to BASEADDR+0x10, then word read same address → ram_wen=1, ram_addr=4, byte_en=4'b1111; read HRDATA=32'hDEADBEEF, HREADYOUT=1 both phases.
- Byte write 8'hA5 to offset 0x13 over 32'h0 → byte_en=4'b1000; readback 32'hA500_0000. Halfword 16'h1234 to 0x12 → byte_en=4'b1100.
- Halfword at 0x11 → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
- Address BASEADDR+SIZE_WORDS*4 and HSIZE=3 → two-cycle ERROR each, ram_wen never asserted.
- Back-to-back NONSEQ write/read/write/read alternating addresses → all zero-wait, read data reflects prior writes.
- Assert rst during WR_DP → ram_wen deasserts immediately; after release, all outputs at reset values, target word unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
// Imported by the byte-lane decoder and the SRAM slave top.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DP,
        ST_RD_DP,
        ST_ERR1,
        ST_ERR2
    } sram_slave_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Maps transfer size and low address bits to SRAM byte lanes.
// Also flags misaligned or unsupported sizes.
module ahb_byte_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] byte_en,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        byte_en = 4'b0000;
        illegal = 1'b0;
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            SIZE_WORD: begin
                byte_en = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave front end for the on-chip SRAM: zero-wait legal transfers,
// two-cycle ERROR response for out-of-range, misaligned or oversized ones.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDRBIT    = 16,
    parameter int unsigned DATABIT    = 32,
    parameter logic [31:0] BASEADDR   = 32'h0000_0000,
    parameter int unsigned SIZE_WORDS = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic               HREADY,
    input  logic [DATABIT-1:0] HWDATA,
    output logic [DATABIT-1:0] HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [ADDRBIT-1:0] ram_addr,
    output logic [DATABIT-1:0] ram_wdata,
    output logic               ram_wen,
    output logic [3:0]         ram_byte_en,
    input  logic [DATABIT-1:0] ram_rdata
);

    localparam logic [32:0] WINDOW_BYTES = 33'(SIZE_WORDS) << 2;

    sram_slave_state_t  state_q, state_d;
    logic [ADDRBIT-1:0] addr_q;
    logic [3:0]         byte_en_q;

    logic        accept, take, illegal, lane_illegal;
    logic [3:0]  lane_en;
    logic [32:0] offset;

    ahb_byte_lane_decode u_lane_decode (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .byte_en (lane_en),
        .illegal (lane_illegal)
    );

    // A borrow out of the 33-bit subtraction means the address sits below the window.
    assign offset  = {1'b0, HADDR} - {1'b0, BASEADDR};
    assign illegal = lane_illegal | offset[32] | (offset >= WINDOW_BYTES);

    assign accept = HSEL && HREADY &&
                    ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));
    assign take   = accept && (state_q != ST_ERR1);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            byte_en_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                addr_q    <= offset[ADDRBIT+1:2];
                byte_en_q <= lane_en;
            end
        end
    end

    always_comb begin
        state_d     = ST_IDLE;
        HREADYOUT   = 1'b1;
        HRESP       = HRESP_OKAY;
        ram_wen     = 1'b0;
        ram_byte_en = 4'b0000;
        case (state_q)
            ST_ERR1: begin
                state_d   = ST_ERR2;
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                if (accept)
                    state_d = illegal ? ST_ERR1 : (HWRITE ? ST_WR_DP : ST_RD_DP);
                if (state_q == ST_WR_DP) begin
                    ram_wen     = 1'b1;
                    ram_byte_en = byte_en_q;
                end
                if (state_q == ST_ERR2)
                    HRESP = HRESP_ERROR;
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = HWDATA;
    assign HRDATA    = ram_rdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave with a behavioural SRAM; the driver queues
// hand-computed per-cycle expectations, a negedge monitor pops and compares them.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = TRANS_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = SIZE_WORD;
    logic        HREADY = 1'b1;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wen;
    logic [3:0]  ram_byte_en;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:65535];
    logic [31:0] next_wdata = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic        rdy;
        logic        resp;
        logic        wen;
        logic [3:0]  ben;
        logic        chk_addr;
        logic [15:0] addr;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    ahb_sram_slave dut (
        .clk         (clk),
        .rst         (rst),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HREADY      (HREADY),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wen     (ram_wen),
        .ram_byte_en (ram_byte_en),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: combinational read, byte-masked write on the rising edge.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_wen)
            for (int b = 0; b < 4; b++)
                if (ram_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic rdy, input logic resp, input logic wen,
                                input logic [3:0] ben, input logic ca, input logic [15:0] a,
                                input logic cr, input logic [31:0] rd, input logic [31:0] wd);
        exp_t e;
        e.cyc = 0; e.name = n; e.rdy = rdy; e.resp = resp; e.wen = wen; e.ben = ben;
        e.chk_addr = ca; e.addr = a; e.chk_rdata = cr; e.rdata = rd; e.wdata = wd;
        return e;
    endfunction

    function automatic exp_t e_idle(input string n);
        return mk(n, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
    endfunction
    function automatic exp_t e_reset(input string n);
        return mk(n, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 16'h0, 1'b1, 32'h0, 32'h0);
    endfunction
    function automatic exp_t e_wr(input string n, input logic [15:0] a, input logic [3:0] ben,
                                  input logic [31:0] wd);
        return mk(n, 1'b1, 1'b0, 1'b1, ben, 1'b1, a, 1'b0, 32'h0, wd);
    endfunction
    function automatic exp_t e_rd(input string n, input logic [15:0] a, input logic [31:0] rd);
        return mk(n, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, a, 1'b1, rd, 32'h0);
    endfunction
    function automatic exp_t e_err1(input string n);
        return mk(n, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
    endfunction
    function automatic exp_t e_err2(input string n);
        return mk(n, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
    endfunction

    // One bus cycle: present an address phase, carry the previous write data,
    // and queue what the following data-phase cycle must look like.
    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy, input exp_t e);
        @(posedge clk); #1;
        HWDATA = next_wdata;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HREADY = rdy;
        next_wdata = wdata;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Assert reset in the cycle after the last drive (its data phase), release one cycle later.
    task automatic reset_pulse();
        @(posedge clk); #1;
        HWDATA = next_wdata;
        HSEL   = 1'b0;
        HTRANS = TRANS_IDLE;
        rst    = 1'b1;
        next_wdata = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        cur = e_reset("post_rst");
        cur.cyc = cyc;
        sb.push_back(cur);
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc != cyc) begin
                check({cur.name, "_cycle"}, cyc, cur.cyc);
            end else begin
                check({cur.name, "_hreadyout"}, 32'(HREADYOUT), 32'(cur.rdy));
                check({cur.name, "_hresp"}, 32'(HRESP), 32'(cur.resp));
                check({cur.name, "_wen"}, 32'(ram_wen), 32'(cur.wen));
                check({cur.name, "_byte_en"}, 32'(ram_byte_en), 32'(cur.ben));
                if (cur.chk_addr) check({cur.name, "_addr"}, 32'(ram_addr), 32'(cur.addr));
                if (cur.wen) check({cur.name, "_wdata"}, ram_wdata, cur.wdata);
                if (cur.chk_rdata) check({cur.name, "_hrdata"}, HRDATA, cur.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        cur = e_reset("reset");
        cur.cyc = cyc;
        sb.push_back(cur);
        @(posedge clk); #1;
        rst = 1'b0;

        // Word write then read-back, then byte/halfword lane writes over a cleared word
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 1, e_wr("wr_word", 16'h4, 4'hF, 32'hDEADBEEF));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0, 1, e_rd("rd_word", 16'h4, 32'hDEADBEEF));
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h10, 32'h0, 1, e_wr("clr_word", 16'h4, 4'hF, 32'h0));
        drive(1, TRANS_NONSEQ, 1, SIZE_BYTE, 32'h13, 32'hA500_0000, 1, e_wr("wr_byte", 16'h4, 4'h8, 32'hA500_0000));
        drive(1, TRANS_SEQ, 0, SIZE_WORD, 32'h10, 32'h0, 1, e_rd("rd_byte", 16'h4, 32'hA500_0000));
        drive(1, TRANS_NONSEQ, 1, SIZE_HALF, 32'h12, 32'h1234_0000, 1, e_wr("wr_half", 16'h4, 4'hC, 32'h1234_0000));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0, 1, e_rd("rd_half", 16'h4, 32'h1234_0000));

        // Misaligned halfword, next transfer presented during ERR2
        drive(1, TRANS_NONSEQ, 1, SIZE_HALF, 32'h11, 32'hFFFF_FFFF, 1, e_err1("mis_err1"));
        drive(0, TRANS_IDLE, 0, SIZE_WORD, 32'h0, 32'h0, 0, e_err2("mis_err2"));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0, 1, e_rd("rd_after_err", 16'h4, 32'h1234_0000));

        // First byte past the window, then an unsupported size
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h0004_0000, 32'h5A5A_5A5A, 1, e_err1("oor_err1"));
        drive(0, TRANS_IDLE, 0, SIZE_WORD, 32'h0, 32'h0, 0, e_err2("oor_err2"));
        drive(1, TRANS_NONSEQ, 1, 3'd3, 32'h20, 32'h6B6B_6B6B, 1, e_err1("size_err1"));
        drive(0, TRANS_IDLE, 0, SIZE_WORD, 32'h0, 32'h0, 0, e_err2("size_err2"));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h0, 32'h0, 1, e_rd("rd_word0", 16'h0, 32'h0));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h20, 32'h0, 1, e_rd("rd_word8", 16'h8, 32'h0));

        // Back-to-back alternating writes and reads
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h100, 32'h1111_1111, 1, e_wr("b2b_w0", 16'h40, 4'hF, 32'h1111_1111));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h100, 32'h0, 1, e_rd("b2b_r0", 16'h40, 32'h1111_1111));
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h204, 32'h2222_2222, 1, e_wr("b2b_w1", 16'h81, 4'hF, 32'h2222_2222));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h204, 32'h0, 1, e_rd("b2b_r1", 16'h81, 32'h2222_2222));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h100, 32'h0, 1, e_rd("b2b_r2", 16'h40, 32'h1111_1111));

        // BUSY and unselected transfers must not touch the SRAM
        drive(1, TRANS_BUSY, 1, SIZE_WORD, 32'h100, 32'h7777_7777, 1, e_idle("busy"));
        drive(0, TRANS_NONSEQ, 1, SIZE_WORD, 32'h100, 32'h7777_7777, 1, e_idle("unsel"));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h100, 32'h0, 1, e_rd("rd_after_busy", 16'h40, 32'h1111_1111));

        // Last word of the window
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h0003_FFFC, 32'hCAFE_F00D, 1, e_wr("wr_last", 16'hFFFF, 4'hF, 32'hCAFE_F00D));
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h0003_FFFC, 32'h0, 1, e_rd("rd_last", 16'hFFFF, 32'hCAFE_F00D));

        // Reset during a write data phase drops the write
        drive(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h204, 32'h9999_9999, 1, e_reset("rst_mid"));
        reset_pulse();
        drive(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h204, 32'h0, 1, e_rd("rd_after_rst", 16'h81, 32'h2222_2222));
        drive(0, TRANS_IDLE, 0, SIZE_WORD, 32'h0, 32'h0, 1, e_idle("tail0"));
        drive(0, TRANS_IDLE, 0, SIZE_WORD, 32'h0, 32'h0, 1, e_idle("tail1"));

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
